rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer.sv | 147 ++++++++++++++
 tb/tb_rx_deframer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// rx_deframer
//   Serial receive deframer. Waits for a falling edge on an idle-high line, then
//   uses the upstream bit sampling counter's centre strobe to check the start bit,
//   shift in DATA_BITS data bits LSB first and check STOP_BITS stop bits. Accepted
//   characters land in a one-deep holding register handshaked with valid/ack.
//
// Parameters
//   DATA_BITS   data bits per frame (LSB first, at least 2)
//   STOP_BITS   stop bits checked (1 or 2)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   data_in      synchronised serial line, idle high
//   sample_tick  one-cycle strobe at each bit centre
//   bsc_clr      holds the upstream bit sampling counter cleared while idle
//   char_out     last accepted character
//   char_valid   char_out holds an unconsumed character
//   char_ack     consumer takes char_out when char_valid and char_ack are high
//   framing_err  one-cycle pulse on a bad stop bit
//   overrun      sticky, set when a character is lost; cleared only by reset
//   busy         high whenever a frame is in progress
module rx_deframer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic                 sample_tick,
    output logic                 bsc_clr,
    output logic [DATA_BITS-1:0] char_out,
    output logic                 char_valid,
    input  logic                 char_ack,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    // Wide enough to hold DATA_BITS, so the count never wraps inside a frame.
    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] BitLast = CntW'(DATA_BITS - 1);
    localparam logic [1:0] StopLast = 2'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e               state;
    logic [CntW-1:0]      bit_cnt;
    logic [1:0]           stop_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 commit;

    // Final good stop bit: the assembled character is handed to the holding register.
    assign commit = (state == StStop) && sample_tick && data_in && (stop_cnt == StopLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            bit_cnt     <= '0;
            stop_cnt    <= '0;
            shift_reg   <= '0;
            bsc_clr     <= 1'b1;
            busy        <= 1'b0;
            framing_err <= 1'b0;
            char_out    <= '0;
            char_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= 1'b0;

            case (state)
                // Line is watched every cycle here; sample_tick is meaningless while
                // the bit sampling counter is held cleared.
                StIdle: begin
                    if (!data_in) begin
                        state   <= StStart;
                        bsc_clr <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                StStart: begin
                    if (sample_tick) begin
                        if (!data_in) begin
                            state   <= StData;
                            bit_cnt <= '0;
                        end else begin
                            // Glitch shorter than half a bit: quietly re-arm.
                            state   <= StIdle;
                            bsc_clr <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (sample_tick) begin
                        shift_reg <= {data_in, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BitLast) begin
                            state    <= StStop;
                            stop_cnt <= '0;
                        end
                    end
                end
                StStop: begin
                    if (sample_tick) begin
                        if (!data_in) begin
                            framing_err <= 1'b1;
                            state       <= StIdle;
                            bsc_clr     <= 1'b1;
                            busy        <= 1'b0;
                        end else if (stop_cnt == StopLast) begin
                            state   <= StIdle;
                            bsc_clr <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    bsc_clr <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase

            // Holding register: a commit into a full, unacknowledged register loses
            // the new character; an ack in the commit cycle frees the slot for it.
            if (commit) begin
                if (!char_valid || char_ack) begin
                    char_out   <= shift_reg;
                    char_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (char_valid && char_ack) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer
//   Self-checking bench for rx_deframer (DATA_BITS=8, STOP_BITS=1). Frames are
//   driven one bit per sample_tick; the character each frame should leave in
//   char_out is pushed to a scoreboard queue and popped when the commit edge has
//   passed.
module tb_rx_deframer;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic       sample_tick;
    logic       bsc_clr;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ack;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int fe_cycles = 0;
    logic ack_hold = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_c;

    rx_deframer #(
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .sample_tick(sample_tick),
        .bsc_clr    (bsc_clr),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ack   (char_ack),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of cycles framing_err was seen high.
    always @(negedge clk) if (framing_err === 1'b1) fe_cycles++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bit: a quiet cycle, then a tick cycle. pre_valid is char_valid just
    // before the tick edge; ack asserts char_ack only in the tick cycle.
    task automatic tick_bit(input logic b, input logic ack, output logic pre_valid);
        data_in = b;
        step();
        sample_tick = 1'b1;
        char_ack = ack | ack_hold;
        @(negedge clk);
        pre_valid = char_valid;
        step();
        sample_tick = 1'b0;
        char_ack = ack_hold;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ack,
                              output logic pre_valid);
        logic pv;
        data_in = 1'b0;
        step();
        step();
        tick_bit(1'b0, 1'b0, pv);
        for (int i = 0; i < 8; i++) tick_bit(d[i], 1'b0, pv);
        tick_bit(stop_bit, ack, pre_valid);
        data_in = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_in = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bsc_clr !== 1'b1) begin bad++; $display("FAIL reset_bsc_clr got=%0b want=1", bsc_clr); end
        total++; if (char_out !== 8'h00) begin bad++; $display("FAIL reset_char_out got=%h want=00", char_out); end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", char_valid); end
        total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%0b want=0", framing_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        // Ticks while idle must not start anything.
        sample_tick = 1'b1;
        step();
        step();
        sample_tick = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_tick_busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic();
        logic pv;
        int fe0;
        fe0 = fe_cycles;
        data_in = 1'b0;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        total++; if (bsc_clr !== 1'b0) begin bad++; $display("FAIL basic_bsc_run got=%0b want=0", bsc_clr); end
        step();
        tick_bit(1'b0, 1'b0, pv);
        exp_q.push_back(8'h4A);
        for (int i = 0; i < 8; i++) tick_bit(((8'h4A >> i) & 8'h01) != 0, 1'b0, pv);
        tick_bit(1'b1, 1'b0, pv);
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", pv); end
        total++; if (char_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", char_valid); end
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c) begin bad++; $display("FAIL basic_char got=%h want=%h", char_out, exp_c); end
        total++; if (fe_cycles != fe0) begin bad++; $display("FAIL basic_fe got=%0d want=0", fe_cycles - fe0); end
        total++; if (busy !== 1'b0 || bsc_clr !== 1'b1) begin bad++; $display("FAIL basic_idle got=%0b%0b want=01", busy, bsc_clr); end
        step();
        total++; if (char_valid !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0b want=1", char_valid); end
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got=%0b want=0", char_valid); end
        // Ack with nothing held has no effect.
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
        total++; if (char_valid !== 1'b0 || char_out !== 8'h4A) begin bad++; $display("FAIL basic_idle_ack got=%0b/%h want=0/4a", char_valid, char_out); end
    endtask

    task automatic test_false_start();
        int fe0;
        fe0 = fe_cycles;
        data_in = 1'b0;
        step();
        total++; if (bsc_clr !== 1'b0) begin bad++; $display("FAIL false_start_run got=%0b want=0", bsc_clr); end
        data_in = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        total++; if (bsc_clr !== 1'b1) begin bad++; $display("FAIL false_start_bsc got=%0b want=1", bsc_clr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy got=%0b want=0", busy); end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL false_start_valid got=%0b want=0", char_valid); end
        total++; if (fe_cycles != fe0 || overrun !== 1'b0) begin bad++; $display("FAIL false_start_flags got=%0d/%0b want=0/0", fe_cycles - fe0, overrun); end
    endtask

    task automatic test_framing();
        logic pv;
        int fe0;
        fe0 = fe_cycles;
        send_frame(8'h55, 1'b0, 1'b0, pv);
        total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL fe_pulse got=%0b want=1", framing_err); end
        step();
        total++; if (fe_cycles - fe0 != 1) begin bad++; $display("FAIL fe_width got=%0d want=1", fe_cycles - fe0); end
        total++; if (char_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fe_state got=%0b/%0b want=0/0", char_valid, busy); end
        // A bad frame must not disturb a held character.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, pv);
        send_frame(8'h55, 1'b0, 1'b0, pv);
        step();
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c || char_valid !== 1'b1) begin bad++; $display("FAIL fe_keep got=%h/%0b want=%h/1", char_out, char_valid, exp_c); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fe_overrun got=%0b want=0", overrun); end
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
    endtask

    task automatic test_overrun();
        logic pv;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, pv);
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c) begin bad++; $display("FAIL ovr_first got=%h want=%h", char_out, exp_c); end
        exp_q.push_back(8'h11);
        send_frame(8'h22, 1'b1, 1'b0, pv);
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c || char_valid !== 1'b1) begin bad++; $display("FAIL ovr_keep got=%h/%0b want=%h/1", char_out, char_valid, exp_c); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want=1", overrun); end
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b want=1", overrun); end
        // Repeat from a clean start, acking in the commit cycle of the second frame.
        do_reset();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, pv);
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c) begin bad++; $display("FAIL ovr2_first got=%h want=%h", char_out, exp_c); end
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1, pv);
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c || char_valid !== 1'b1) begin bad++; $display("FAIL ovr2_load got=%h/%0b want=%h/1", char_out, char_valid, exp_c); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr2_clear got=%0b want=0", overrun); end
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic pv;
        int fe0;
        fe0 = fe_cycles;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0, pv);
        data_in = 1'b0;
        step();
        step();
        tick_bit(1'b0, 1'b0, pv);
        for (int i = 0; i < 4; i++) tick_bit(i[0], 1'b0, pv);
        rst_n = 1'b0;
        data_in = 1'b1;
        step();
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        total++; if (char_out !== 8'h00 || char_valid !== 1'b0) begin bad++; $display("FAIL mrst_char got=%h/%0b want=00/0", char_out, char_valid); end
        total++; if (busy !== 1'b0 || bsc_clr !== 1'b1) begin bad++; $display("FAIL mrst_state got=%0b%0b want=01", busy, bsc_clr); end
        total++; if (framing_err !== 1'b0 || overrun !== 1'b0 || fe_cycles != fe0) begin bad++; $display("FAIL mrst_flags got=%0b/%0b/%0d want=0/0/0", framing_err, overrun, fe_cycles - fe0); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_stay_idle got=%0b want=0", busy); end
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, pv);
        exp_c = exp_q.pop_front();
        total++; if (char_out !== exp_c || char_valid !== 1'b1) begin bad++; $display("FAIL mrst_next got=%h/%0b want=%h/1", char_out, char_valid, exp_c); end
        char_ack = 1'b1;
        step();
        char_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic pv;
        ack_hold = 1'b1;
        char_ack = 1'b1;
        for (int f = 1; f <= 2; f++) begin
            exp_q.push_back(8'(f));
            send_frame(8'(f), 1'b1, 1'b0, pv);
            exp_c = exp_q.pop_front();
            total++; if (char_out !== exp_c || char_valid !== 1'b1) begin bad++; $display("FAIL b2b_load got=%h/%0b want=%h/1", char_out, char_valid, exp_c); end
            step();
            total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL b2b_one_clk got=%0b want=0", char_valid); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%0b want=0", overrun); end
        ack_hold = 1'b0;
        char_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        data_in = 1'b1;
        sample_tick = 1'b0;
        char_ack = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
